// File: rtl/op_stream_pkg.sv
// Shared types and helpers for the op-stream pattern player/checker.
package op_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_STREAM,
    ST_FINISH,
    ST_DONE,
    ST_TOUT
  } state_e;

  localparam int LOAD_MODE_DEF = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/op_stream_checker.sv
// Output-side checker: walks the golden ROM, counts mismatches and latches the first failing index.
module op_stream_checker
  import op_stream_pkg::*;
#(
  parameter int OUT_W   = 14,
  parameter int GOLD_AW = 12,
  parameter int ERR_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_out_valid,
  input  logic [OUT_W-1:0]   i_out_data,
  input  logic [OUT_W-1:0]   i_gold_word,
  input  logic [GOLD_AW:0]   i_gold_count,
  output logic [GOLD_AW:0]   o_out_idx,
  output logic [ERR_W-1:0]   o_err_cnt,
  output logic [GOLD_AW:0]   o_first_err_idx
);

  localparam logic [31:0] ERR_MAX = 32'({ERR_W{1'b1}});

  logic [GOLD_AW:0] out_idx_q, out_idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [GOLD_AW:0] first_err_q, first_err_d;
  logic             miss;

  always_comb begin
    out_idx_d   = out_idx_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    // Words past the expected count are errors even if the data happens to match.
    miss        = (out_idx_q >= i_gold_count) || (i_out_data != i_gold_word);
    if (i_clr) begin
      out_idx_d   = '0;
      err_cnt_d   = '0;
      first_err_d = '1;
    end else if (i_en && i_out_valid) begin
      out_idx_d = out_idx_q + 1'b1;
      if (miss) begin
        err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_MAX));
        if (err_cnt_q == '0) first_err_d = out_idx_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_idx_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '1;
    end else begin
      out_idx_q   <= out_idx_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign o_out_idx       = out_idx_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_first_err_idx = first_err_q;

endmodule

// File: rtl/op_stream_sequencer.sv
// Pattern player: issues ops and input streams from ROMs into a core and reports the checker verdict.
module op_stream_sequencer
  import op_stream_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 14,
  parameter int OP_W        = 4,
  parameter int IN_AW       = 11,
  parameter int OP_AW       = 10,
  parameter int GOLD_AW     = 12,
  parameter int LOAD_MODE   = LOAD_MODE_DEF,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int ERR_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [OP_AW:0]     i_op_count,
  input  logic [IN_AW:0]     i_in_len,
  input  logic [GOLD_AW:0]   i_gold_count,
  output logic [OP_AW-1:0]   o_op_addr,
  input  logic [OP_W-1:0]    i_op_word,
  output logic [IN_AW-1:0]   o_in_addr,
  input  logic [DATA_W-1:0]  i_in_word,
  output logic [GOLD_AW-1:0] o_gold_addr,
  input  logic [OUT_W-1:0]   i_gold_word,
  output logic               o_op_valid,
  output logic [OP_W-1:0]    o_op_mode,
  input  logic               i_op_ready,
  output logic               o_in_valid,
  output logic [DATA_W-1:0]  o_in_data,
  input  logic               i_in_ready,
  input  logic               i_out_valid,
  input  logic [OUT_W-1:0]   i_out_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [ERR_W-1:0]   o_err_cnt,
  output logic [GOLD_AW:0]   o_first_err_idx
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [OP_AW:0]   op_idx_q, op_idx_d;
  logic [IN_AW-1:0] in_idx_q, in_idx_d;
  logic [IN_AW:0]   stream_cnt_q, stream_cnt_d, stream_nxt;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             done_q, done_d, pass_q, pass_d, tout_q, tout_d;
  logic             clr, busy, op_fire, in_xfer, any_hs;
  logic [GOLD_AW:0] out_idx;
  logic [ERR_W-1:0] err_cnt;

  assign busy       = (state_q == ST_WAIT_RDY) || (state_q == ST_ISSUE) ||
                      (state_q == ST_STREAM)   || (state_q == ST_FINISH);
  assign op_fire    = (state_q == ST_ISSUE);
  assign in_xfer    = (state_q == ST_STREAM) && i_in_ready;
  assign any_hs     = op_fire || in_xfer || i_out_valid;
  assign stream_nxt = stream_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    op_idx_d     = op_idx_q;
    in_idx_d     = in_idx_q;
    stream_cnt_d = stream_cnt_q;
    wdog_d       = wdog_q;
    done_d       = done_q;
    pass_d       = pass_q;
    tout_d       = tout_q;
    clr          = 1'b0;
    if (busy) wdog_d = any_hs ? '0 : wdog_q + 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (i_start) begin
          clr          = 1'b1;
          op_idx_d     = '0;
          in_idx_d     = '0;
          stream_cnt_d = '0;
          wdog_d       = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          tout_d       = 1'b0;
          state_d      = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (i_op_ready) state_d = (op_idx_q == i_op_count) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE: begin
        op_idx_d     = op_idx_q + 1'b1;
        stream_cnt_d = '0;
        state_d      = ((i_op_word == OP_W'(LOAD_MODE)) && (i_in_len != '0)) ? ST_STREAM : ST_WAIT_RDY;
      end
      ST_STREAM: begin
        if (in_xfer) begin
          in_idx_d     = in_idx_q + 1'b1;
          stream_cnt_d = stream_nxt;
          if (stream_nxt == i_in_len) state_d = ST_WAIT_RDY;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt == '0) && (out_idx == i_gold_count);
        state_d = ST_DONE;
      end
      default: ;
    endcase
    // Watchdog overrides any other transition once the idle budget is spent.
    if (busy && !any_hs && (wdog_q == WD_LAST)) begin
      state_d = ST_TOUT;
      done_d  = 1'b1;
      tout_d  = 1'b1;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      op_idx_q     <= '0;
      in_idx_q     <= '0;
      stream_cnt_q <= '0;
      wdog_q       <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_idx_q     <= op_idx_d;
      in_idx_q     <= in_idx_d;
      stream_cnt_q <= stream_cnt_d;
      wdog_q       <= wdog_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      tout_q       <= tout_d;
    end
  end

  op_stream_checker #(
    .OUT_W  (OUT_W),
    .GOLD_AW(GOLD_AW),
    .ERR_W  (ERR_W)
  ) u_checker (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clr          (clr),
    .i_en           (state_q != ST_IDLE),
    .i_out_valid    (i_out_valid),
    .i_out_data     (i_out_data),
    .i_gold_word    (i_gold_word),
    .i_gold_count   (i_gold_count),
    .o_out_idx      (out_idx),
    .o_err_cnt      (err_cnt),
    .o_first_err_idx(o_first_err_idx)
  );

  assign o_op_addr   = op_idx_q[OP_AW-1:0];
  assign o_in_addr   = in_idx_q;
  assign o_gold_addr = out_idx[GOLD_AW-1:0];
  assign o_op_valid  = op_fire;
  assign o_op_mode   = op_fire ? i_op_word : '0;
  assign o_in_valid  = (state_q == ST_STREAM);
  assign o_in_data   = o_in_valid ? i_in_word : '0;
  assign o_busy      = busy;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_timeout   = tout_q;
  assign o_err_cnt   = err_cnt;

endmodule
